pipe_ctrl: RTL

Pipeline sequencing controller for the three-stage core (fetch / decode / execute). It owns the stall and flush controls of `pc_reg`, `if_id` and `id_ex`, and redirects the PC on taken jumps and branches from `ex`. It inserts a one-cycle bubble on load-use hazards against the register addresses decode presents, and freezes the whole pipeline while the bus arbiter holds the core. It also keeps stall and flush event counters for debug.

---
 rtl/pipe_ctrl_if.sv | 47 ++++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the pipeline stages / bus arbiter.
// The master side drives the hazard sources; the slave side is the controller.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             jump_en_i;
   logic [31:0]      jump_addr_i;
   logic             ex_is_load_i;
   logic [4:0]       ex_rd_addr_i;
   logic             ex_reg_wen_i;
   logic [4:0]       id_rs1_addr_i;
   logic [4:0]       id_rs2_addr_i;
   logic             hold_req_i;
   logic             hold_ack_o;
   logic             hold_pc_o;
   logic             hold_if_id_o;
   logic             hold_id_ex_o;
   logic             flush_if_id_o;
   logic             flush_id_ex_o;
   logic             jump_o;
   logic [31:0]      jump_addr_o;
   logic             hold_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output jump_en_i, jump_addr_i,
      output ex_is_load_i, ex_rd_addr_i, ex_reg_wen_i,
      output id_rs1_addr_i, id_rs2_addr_i,
      output hold_req_i,
      input  hold_ack_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
      input  flush_if_id_o, flush_id_ex_o,
      input  jump_o, jump_addr_o,
      input  hold_timeout_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  jump_en_i, jump_addr_i,
      input  ex_is_load_i, ex_rd_addr_i, ex_reg_wen_i,
      input  id_rs1_addr_i, id_rs2_addr_i,
      input  hold_req_i,
      output hold_ack_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
      output flush_if_id_o, flush_id_ex_o,
      output jump_o, jump_addr_o,
      output hold_timeout_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect sequencing for the fetch/decode/execute pipeline,
// with bus-hold freeze, hold watchdog and debug event counters.
module pipe_ctrl #(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam logic [7:0] HoldMax = 8'(HOLD_MAX);

   state_e           state_q, state_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             load_use;
   logic             hold_ack;
   logic             hold_pc;
   logic             hold_if_id;
   logic             hold_id_ex;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             jump;
   logic [31:0]      jump_addr;

   // A load in ex whose rd feeds decode cannot be forwarded in time.
   always_comb begin
      load_use = bus.ex_is_load_i
               & bus.ex_reg_wen_i
               & (bus.ex_rd_addr_i != 5'd0)
               & ((bus.ex_rd_addr_i == bus.id_rs1_addr_i)
                | (bus.ex_rd_addr_i == bus.id_rs2_addr_i));
   end

   // Next state and per-cycle pipeline controls; all forced low in reset.
   always_comb begin
      state_d     = state_q;
      hold_ack    = 1'b0;
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump        = 1'b0;
      jump_addr   = 32'd0;
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (bus.jump_en_i) begin
                  jump        = 1'b1;
                  jump_addr   = bus.jump_addr_i;
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
                  state_d     = FLUSH;
               end else begin
                  if (load_use) begin
                     hold_pc     = 1'b1;
                     hold_if_id  = 1'b1;
                     flush_id_ex = 1'b1;
                  end
                  if (bus.hold_req_i) begin
                     state_d = HOLD;
                  end
               end
            end
            FLUSH: begin
               flush_if_id = 1'b1;
               state_d     = bus.hold_req_i ? HOLD : RUN;
            end
            HOLD: begin
               hold_ack   = 1'b1;
               hold_pc    = 1'b1;
               hold_if_id = 1'b1;
               hold_id_ex = 1'b1;
               if (!bus.hold_req_i) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // Hold watchdog and debug counters.
   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q + CNT_W'(hold_pc);
      flush_cnt_d = flush_cnt_q + CNT_W'(jump);
      if (state_q == HOLD) begin
         if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
         end
         if (hold_cnt_d >= HoldMax) begin
            timeout_d = 1'b1;
         end
      end else if (state_d == HOLD) begin
         hold_cnt_d = 8'd0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         hold_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Drive the bundle outputs.
   always_comb begin
      bus.hold_ack_o     = hold_ack;
      bus.hold_pc_o      = hold_pc;
      bus.hold_if_id_o   = hold_if_id;
      bus.hold_id_ex_o   = hold_id_ex;
      bus.flush_if_id_o  = flush_if_id;
      bus.flush_id_ex_o  = flush_id_ex;
      bus.jump_o         = jump;
      bus.jump_addr_o    = jump_addr;
      bus.hold_timeout_o = timeout_q;
      bus.stall_cnt_o    = stall_cnt_q;
      bus.flush_cnt_o    = flush_cnt_q;
   end

endmodule
